// File: rtl/prn_msg_pkg.sv
// Shared definitions for the PRN / navigation-message player.
//   - default parameter values
//   - encoding of the load target (code or message memory)
//   - load FSM state type
//   - ceil_div / idx_w helpers used to size memories and pointers
package prn_msg_pkg;

    localparam int DEF_NUM_CH         = 8;
    localparam int DEF_CODE_LEN       = 1023;
    localparam int DEF_MSG_LEN        = 1500;
    localparam int DEF_EPOCHS_PER_BIT = 1;
    localparam int WORD_W             = 32;

    typedef enum logic {
        TGT_CODE = 1'b0,
        TGT_MSG  = 1'b1
    } wr_target_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } load_state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Width of an index into n entries, never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prn_msg_player_if.sv
// Load-port bundle of prn_msg_player.
//   wr_start  : one-cycle pulse opening a load session
//   wr_sel    : target channel, sampled on wr_start
//   wr_target : 0 = code memory, 1 = message memory, sampled on wr_start
//   wr_data / wr_valid / wr_ready : 32-bit word stream, valid/ready handshake
//   wr_done   : one-cycle pulse after the last word of a session is accepted
// master = the loader, slave = the player.
interface prn_msg_player_if #(
    parameter int SEL_W = 3
);
    logic             wr_start;
    logic [SEL_W-1:0] wr_sel;
    logic             wr_target;
    logic [31:0]      wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic             wr_done;

    modport master (
        output wr_start, wr_sel, wr_target, wr_data, wr_valid,
        input  wr_ready, wr_done
    );

    modport slave (
        input  wr_start, wr_sel, wr_target, wr_data, wr_valid,
        output wr_ready, wr_done
    );
endinterface

// File: rtl/prn_msg_channel.sv
// One playback channel: chip counter, code-phase delay (pending/active),
// epoch counter, message pointer and the registered chip outputs.
//   clk, rst_n            : clock, asynchronous active-low reset
//   enable                : run enable (level); low clears the counters
//   chip_en               : one-cycle chip strobe
//   delay, delay_load     : requested code delay and its capture strobe
//   rd_addr, msg_ptr      : current code / message read addresses (to memories)
//   code_bit, msg_bit     : memory bits at rd_addr / msg_ptr
//   data_ca/msg/out       : registered code chip, message bit and their XOR
//   epoch, msg_wrap       : one-cycle pulses at code epoch and message wrap
module prn_msg_channel
    import prn_msg_pkg::*;
#(
    parameter  int CODE_LEN       = DEF_CODE_LEN,
    parameter  int MSG_LEN        = DEF_MSG_LEN,
    parameter  int EPOCHS_PER_BIT = DEF_EPOCHS_PER_BIT,
    localparam int CODE_AW        = $clog2(CODE_LEN),
    localparam int MSG_AW         = $clog2(MSG_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               chip_en,
    input  logic               delay_load,
    input  logic [CODE_AW-1:0] delay,
    output logic [CODE_AW-1:0] rd_addr,
    output logic [MSG_AW-1:0]  msg_ptr,
    input  logic               code_bit,
    input  logic               msg_bit,
    output logic               data_ca,
    output logic               data_msg,
    output logic               data_out,
    output logic               epoch,
    output logic               msg_wrap
);

    localparam int EP_W = idx_w(EPOCHS_PER_BIT);

    logic [CODE_AW-1:0] cnt_reg, cnt_next;
    logic [CODE_AW-1:0] act_reg, act_next;
    logic [CODE_AW-1:0] pend_reg, pend_next;
    logic [EP_W-1:0]    ep_cnt_reg, ep_cnt_next;
    logic [MSG_AW-1:0]  msg_ptr_reg, msg_ptr_next;
    logic               ca_reg, ca_next;
    logic               msg_reg, msg_next;
    logic               out_reg, out_next;
    logic               epoch_reg, epoch_next;
    logic               wrap_reg, wrap_next;

    // Code phase = (cnt - active delay) mod CODE_LEN, without a divider.
    always_comb begin
        if (cnt_reg >= act_reg) begin
            rd_addr = cnt_reg - act_reg;
        end else begin
            rd_addr = CODE_AW'(({1'b0, cnt_reg} + (CODE_AW+1)'(CODE_LEN))
                               - {1'b0, act_reg});
        end
    end

    always_comb begin
        logic at_epoch;
        logic bit_done;

        cnt_next     = cnt_reg;
        act_next     = act_reg;
        pend_next    = pend_reg;
        ep_cnt_next  = ep_cnt_reg;
        msg_ptr_next = msg_ptr_reg;
        epoch_next   = 1'b0;
        wrap_next    = 1'b0;
        at_epoch     = chip_en && (rd_addr == CODE_AW'(CODE_LEN - 1));
        bit_done     = (ep_cnt_reg == EP_W'(EPOCHS_PER_BIT - 1));

        // Out-of-range delays saturate to the last code phase.
        if (delay_load) begin
            if ({1'b0, delay} >= (CODE_AW+1)'(CODE_LEN)) begin
                pend_next = CODE_AW'(CODE_LEN - 1);
            end else begin
                pend_next = delay;
            end
        end

        if (!enable) begin
            cnt_next     = '0;
            ep_cnt_next  = '0;
            msg_ptr_next = '0;
        end else if (chip_en) begin
            cnt_next = (cnt_reg == CODE_AW'(CODE_LEN - 1)) ? '0 : cnt_reg + 1'b1;
            if (at_epoch) begin
                epoch_next = 1'b1;
                // Commit the delay captured before this strobe; a load in the
                // same cycle stays pending for the following epoch.
                act_next   = pend_reg;
                if (bit_done) begin
                    ep_cnt_next = '0;
                    if (msg_ptr_reg == MSG_AW'(MSG_LEN - 1)) begin
                        msg_ptr_next = '0;
                        wrap_next    = 1'b1;
                    end else begin
                        msg_ptr_next = msg_ptr_reg + 1'b1;
                    end
                end else begin
                    ep_cnt_next = ep_cnt_reg + 1'b1;
                end
            end
        end

        ca_next  = enable & code_bit;
        msg_next = enable & msg_bit;
        out_next = enable & (code_bit ^ msg_bit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            act_reg     <= '0;
            pend_reg    <= '0;
            ep_cnt_reg  <= '0;
            msg_ptr_reg <= '0;
            ca_reg      <= 1'b0;
            msg_reg     <= 1'b0;
            out_reg     <= 1'b0;
            epoch_reg   <= 1'b0;
            wrap_reg    <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            act_reg     <= act_next;
            pend_reg    <= pend_next;
            ep_cnt_reg  <= ep_cnt_next;
            msg_ptr_reg <= msg_ptr_next;
            ca_reg      <= ca_next;
            msg_reg     <= msg_next;
            out_reg     <= out_next;
            epoch_reg   <= epoch_next;
            wrap_reg    <= wrap_next;
        end
    end

    assign msg_ptr  = msg_ptr_reg;
    assign data_ca  = ca_reg;
    assign data_msg = msg_reg;
    assign data_out = out_reg;
    assign epoch    = epoch_reg;
    assign msg_wrap = wrap_reg;

endmodule

// File: rtl/prn_msg_player.sv
// Multi-channel PRN code / navigation message player.
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr                : load port (slave side of prn_msg_player_if)
//   ch_enable         : per-channel run enable
//   chip_en           : per-channel chip strobes
//   delay, delay_load : per-channel code delay (CODE_AW bits each) and strobes
//   data_ca/msg/out   : per-channel registered code chip, message bit, XOR
//   epoch, msg_wrap   : per-channel epoch and message-wrap pulses
// Each channel owns a code memory and a message memory (32-bit words,
// bit j of word k = bit index 32k+j). One load session fills one memory.
module prn_msg_player
    import prn_msg_pkg::*;
#(
    parameter  int NUM_CH         = DEF_NUM_CH,
    parameter  int CODE_LEN       = DEF_CODE_LEN,
    parameter  int MSG_LEN        = DEF_MSG_LEN,
    parameter  int EPOCHS_PER_BIT = DEF_EPOCHS_PER_BIT,
    localparam int CODE_AW        = $clog2(CODE_LEN)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    prn_msg_player_if.slave           wr,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [NUM_CH-1:0]         chip_en,
    input  logic [NUM_CH*CODE_AW-1:0] delay,
    input  logic [NUM_CH-1:0]         delay_load,
    output logic [NUM_CH-1:0]         data_ca,
    output logic [NUM_CH-1:0]         data_msg,
    output logic [NUM_CH-1:0]         data_out,
    output logic [NUM_CH-1:0]         epoch,
    output logic [NUM_CH-1:0]         msg_wrap
);

    localparam int MSG_AW     = $clog2(MSG_LEN);
    localparam int CODE_WORDS = ceil_div(CODE_LEN, WORD_W);
    localparam int MSG_WORDS  = ceil_div(MSG_LEN, WORD_W);
    localparam int MAX_WORDS  = (CODE_WORDS > MSG_WORDS) ? CODE_WORDS : MSG_WORDS;
    localparam int PTR_W      = $clog2(MAX_WORDS + 1);
    localparam int SEL_W      = idx_w(NUM_CH);
    localparam int CW_AW      = idx_w(CODE_WORDS);
    localparam int MW_AW      = idx_w(MSG_WORDS);

    // ------------------------------------------------------------------
    // Load FSM
    // ------------------------------------------------------------------
    load_state_e state_reg, state_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    wr_target_e       target_reg, target_next;
    logic             done_reg, done_next;
    logic             word_we;

    always_comb begin
        logic [PTR_W-1:0] last_ptr;

        state_next  = state_reg;
        ptr_next    = ptr_reg;
        sel_next    = sel_reg;
        target_next = target_reg;
        done_next   = 1'b0;
        word_we     = 1'b0;
        last_ptr    = (target_reg == TGT_MSG) ? PTR_W'(MSG_WORDS - 1)
                                              : PTR_W'(CODE_WORDS - 1);

        // A start always wins, even over a word handshaking in the same cycle.
        if (wr.wr_start) begin
            state_next  = ST_LOAD;
            ptr_next    = '0;
            sel_next    = wr.wr_sel;
            target_next = wr_target_e'(wr.wr_target);
        end else if (state_reg == ST_LOAD && wr.wr_valid) begin
            word_we  = 1'b1;
            ptr_next = ptr_reg + 1'b1;
            if (ptr_reg == last_ptr) begin
                state_next = ST_IDLE;
                done_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= '0;
            sel_reg    <= '0;
            target_reg <= TGT_CODE;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            sel_reg    <= sel_next;
            target_reg <= target_next;
            done_reg   <= done_next;
        end
    end

    assign wr.wr_ready = (state_reg == ST_LOAD);
    assign wr.wr_done  = done_reg;

    // ------------------------------------------------------------------
    // Per-channel memories and playback
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [31:0]        code_mem [CODE_WORDS];
        logic [31:0]        msg_mem  [MSG_WORDS];
        logic [CODE_AW-1:0] rd_addr;
        logic [MSG_AW-1:0]  msg_ptr;
        logic               code_bit;
        logic               msg_bit;
        logic               sel_hit;

        assign sel_hit = word_we && (sel_reg == SEL_W'(gi));

        // Contents survive reset. Whole words are stored; bits at or beyond
        // the sequence length are simply never addressed.
        always_ff @(posedge clk) begin
            if (sel_hit && target_reg == TGT_CODE) begin
                code_mem[CW_AW'(ptr_reg)] <= wr.wr_data;
            end
            if (sel_hit && target_reg == TGT_MSG) begin
                msg_mem[MW_AW'(ptr_reg)] <= wr.wr_data;
            end
        end

        // Read feeds the channel's output register, so a word written this
        // cycle is seen by playback on the next one.
        assign code_bit = code_mem[CW_AW'(rd_addr >> 5)][5'(rd_addr)];
        assign msg_bit  = msg_mem[MW_AW'(msg_ptr >> 5)][5'(msg_ptr)];

        prn_msg_channel #(
            .CODE_LEN       (CODE_LEN),
            .MSG_LEN        (MSG_LEN),
            .EPOCHS_PER_BIT (EPOCHS_PER_BIT)
        ) u_channel (
            .clk        (clk),
            .rst_n      (rst_n),
            .enable     (ch_enable[gi]),
            .chip_en    (chip_en[gi]),
            .delay_load (delay_load[gi]),
            .delay      (delay[gi*CODE_AW +: CODE_AW]),
            .rd_addr    (rd_addr),
            .msg_ptr    (msg_ptr),
            .code_bit   (code_bit),
            .msg_bit    (msg_bit),
            .data_ca    (data_ca[gi]),
            .data_msg   (data_msg[gi]),
            .data_out   (data_out[gi]),
            .epoch      (epoch[gi]),
            .msg_wrap   (msg_wrap[gi])
        );
    end

endmodule

// File: tb/tb_prn_msg_player.sv
// Randomized bench for prn_msg_player with a scoreboard: the driver computes
// the expected post-edge outputs from a behavioural model and queues them;
// a monitor pops one entry per clock and compares against the DUT.
module tb_prn_msg_player;
    import prn_msg_pkg::*;

    localparam int NCH    = 4;
    localparam int CL     = 37;
    localparam int ML     = 45;
    localparam int EPB    = 3;
    localparam int CAW    = $clog2(CL);
    localparam int CWORDS = ceil_div(CL, 32);
    localparam int MWORDS = ceil_div(ML, 32);
    localparam int SELW   = idx_w(NCH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prn_msg_player_if #(.SEL_W(SELW)) wr_bus ();

    logic [NCH-1:0]     ch_enable, chip_en, delay_load;
    logic [NCH*CAW-1:0] delay;
    logic [NCH-1:0]     data_ca, data_msg, data_out, epoch, msg_wrap;

    prn_msg_player #(
        .NUM_CH         (NCH),
        .CODE_LEN       (CL),
        .MSG_LEN        (ML),
        .EPOCHS_PER_BIT (EPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr         (wr_bus),
        .ch_enable  (ch_enable),
        .chip_en    (chip_en),
        .delay      (delay),
        .delay_load (delay_load),
        .data_ca    (data_ca),
        .data_msg   (data_msg),
        .data_out   (data_out),
        .epoch      (epoch),
        .msg_wrap   (msg_wrap)
    );

    typedef struct packed {
        logic [NCH-1:0] ca;
        logic [NCH-1:0] msg;
        logic [NCH-1:0] out;
        logic [NCH-1:0] ep;
        logic [NCH-1:0] wrap;
        logic           ready;
        logic           done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // ---------------- reference model state ----------------
    // Counters are kept as totals since enable; phase and message position
    // are derived from them with modulo arithmetic.
    int strobes [NCH];
    int epochs  [NCH];
    int act_dly [NCH];
    int pend_dly[NCH];
    bit m_code  [NCH][CL];
    bit m_msg   [NCH][ML];
    bit m_load;
    int m_ptr, m_sel;
    bit m_tgt;
    int sessions_done = 0;
    bit en3 = 1'b0;

    task automatic model_step();
        exp_t e;
        int   rd, d;
        e = '0;
        if (!rst_n) begin
            m_load = 1'b0;
            m_ptr  = 0;
            for (int i = 0; i < NCH; i++) begin
                strobes[i] = 0; epochs[i] = 0; act_dly[i] = 0; pend_dly[i] = 0;
            end
            exp_q.push_back(e);
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            if (ch_enable[i]) begin
                rd = ((strobes[i] % CL) - act_dly[i] + CL) % CL;
                e.ca[i]  = m_code[i][rd];
                e.msg[i] = m_msg[i][(epochs[i] / EPB) % ML];
                e.out[i] = e.ca[i] ^ e.msg[i];
                if (chip_en[i]) begin
                    strobes[i]++;
                    if (rd == CL - 1) begin
                        e.ep[i]    = 1'b1;
                        act_dly[i] = pend_dly[i];
                        epochs[i]++;
                        if (epochs[i] % (EPB * ML) == 0) e.wrap[i] = 1'b1;
                    end
                end
            end else begin
                strobes[i] = 0;
                epochs[i]  = 0;
            end
            if (delay_load[i]) begin
                d = int'(delay[i*CAW +: CAW]);
                pend_dly[i] = (d >= CL) ? CL - 1 : d;
            end
        end
        // Memory updates after the reads: a write is visible one cycle later.
        if (wr_bus.wr_start) begin
            m_load = 1'b1;
            m_ptr  = 0;
            m_sel  = int'(wr_bus.wr_sel);
            m_tgt  = wr_bus.wr_target;
        end else if (m_load && wr_bus.wr_valid) begin
            for (int j = 0; j < 32; j++) begin
                if (m_tgt && (32 * m_ptr + j) < ML) m_msg[m_sel][32 * m_ptr + j] = wr_bus.wr_data[j];
                if (!m_tgt && (32 * m_ptr + j) < CL) m_code[m_sel][32 * m_ptr + j] = wr_bus.wr_data[j];
            end
            m_ptr++;
            if (m_ptr == (m_tgt ? MWORDS : CWORDS)) begin
                m_load = 1'b0;
                e.done = 1'b1;
                sessions_done++;
                $display("session %0d: ch=%0d target=%s loaded", sessions_done, m_sel,
                         m_tgt ? "msg" : "code");
            end
        end
        e.ready = m_load;
        exp_q.push_back(e);
    endtask

    // mode 0: initial loading of every memory; mode 1: playback
    task automatic drive_inputs(input int mode);
        int load_idx;
        wr_bus.wr_start  = 1'b0;
        wr_bus.wr_valid  = 1'b0;
        wr_bus.wr_data   = $urandom;
        wr_bus.wr_sel    = SELW'($urandom);
        wr_bus.wr_target = 1'($urandom);
        for (int i = 0; i < NCH; i++) delay[i*CAW +: CAW] = CAW'($urandom_range(0, (1 << CAW) - 1));
        if (mode == 0) begin
            ch_enable  = '0;
            chip_en    = NCH'($urandom);
            delay_load = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : '0;
            load_idx   = sessions_done;
            if (!m_load) begin
                wr_bus.wr_valid = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 1) == 0) begin
                    wr_bus.wr_start  = 1'b1;
                    wr_bus.wr_sel    = SELW'(load_idx / 2);
                    wr_bus.wr_target = 1'(load_idx % 2);
                end
            end else begin
                wr_bus.wr_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) == 0) begin
                    wr_bus.wr_start  = 1'b1;
                    wr_bus.wr_sel    = SELW'(m_sel);
                    wr_bus.wr_target = m_tgt;
                end
            end
        end else begin
            if ($urandom_range(0, 299) == 0) en3 = ~en3;
            ch_enable = {en3, 3'b111};
            for (int i = 0; i < NCH; i++) begin
                chip_en[i]    = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                delay_load[i] = ($urandom_range(0, 149) == 0);
            end
            if (!m_load) begin
                wr_bus.wr_valid = ($urandom_range(0, 2) == 0);
                wr_bus.wr_start = ($urandom_range(0, 199) == 0);
            end else begin
                wr_bus.wr_valid = ($urandom_range(0, 3) != 0);
                wr_bus.wr_start = ($urandom_range(0, 49) == 0);
            end
        end
    endtask

    // ---------------- monitor ----------------
    exp_t mon_exp, mon_act;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = '{ca: data_ca, msg: data_msg, out: data_out, ep: epoch,
                        wrap: msg_wrap, ready: wr_bus.wr_ready, done: wr_bus.wr_done};
            n_checks++;
            if (mon_act === mon_exp) begin
                n_pass++;
            end else begin
                $display("FAIL outputs t=%0t got ca=%b msg=%b out=%b ep=%b wrap=%b rdy=%b done=%b need ca=%b msg=%b out=%b ep=%b wrap=%b rdy=%b done=%b",
                         $time, mon_act.ca, mon_act.msg, mon_act.out, mon_act.ep, mon_act.wrap,
                         mon_act.ready, mon_act.done, mon_exp.ca, mon_exp.msg, mon_exp.out,
                         mon_exp.ep, mon_exp.wrap, mon_exp.ready, mon_exp.done);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int budget;
        ch_enable = '0; chip_en = '0; delay_load = '0; delay = '0;
        wr_bus.wr_start = 1'b0; wr_bus.wr_valid = 1'b0; wr_bus.wr_data = '0;
        wr_bus.wr_sel = '0; wr_bus.wr_target = 1'b0;
        m_load = 1'b0; m_ptr = 0; m_sel = 0; m_tgt = 1'b0;

        // reset state
        repeat (3) begin
            @(negedge clk);
            drive_inputs(0);
            model_step();
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_inputs(0);
        model_step();

        // load code and message memories of every channel
        budget = 3000;
        while (sessions_done < 2 * NCH && budget > 0) begin
            @(negedge clk);
            drive_inputs(0);
            model_step();
            budget--;
        end
        n_checks++;
        if (sessions_done == 2 * NCH) n_pass++;
        else $display("FAIL initial_load sessions=%0d need=%0d", sessions_done, 2 * NCH);

        // playback with concurrent reloads, delay changes and enable toggles
        repeat (20000) begin
            @(negedge clk);
            drive_inputs(1);
            model_step();
        end

        // asynchronous reset mid-playback: outputs clear without a clock edge
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({data_ca, data_msg, data_out, epoch, msg_wrap, wr_bus.wr_ready, wr_bus.wr_done} === '0) begin
            n_pass++;
        end else begin
            $display("FAIL async_reset got ca=%b msg=%b out=%b ep=%b wrap=%b rdy=%b done=%b need all 0",
                     data_ca, data_msg, data_out, epoch, msg_wrap, wr_bus.wr_ready, wr_bus.wr_done);
        end
        drive_inputs(1);
        model_step();
        repeat (2) begin
            @(negedge clk);
            drive_inputs(1);
            model_step();
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_inputs(1);
        model_step();

        // playback resumes from the start with memory contents intact
        repeat (6000) begin
            @(negedge clk);
            drive_inputs(1);
            model_step();
        end

        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain left=%0d need=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
